cfg_chain_loader: RTL and testbench

- Sequences the serial configuration chain of fabric tiles (connection blocks, CLBs).
- Takes framed 16-bit words from a host-side loader interface over a valid/ready handshake.
- Shifts each frame into the chain head as a start-qualified bit stream: target ID first, then payload chunks.
- Reports completion per frame; one instance per fabric column drives the first config_block of its chain.

---
 rtl/cfg_loader_pkg.sv | 19 +
 rtl/cfg_crc16.sv | 36 +++
 rtl/cfg_chain_loader.sv | 200 ++++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// rtl/cfg_loader_pkg.sv - shared types and constants for the column config-chain loader
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Header word layout: target ID in the low bits, chunk count directly above it.
    localparam int HDR_ID_LSB = 0;

    // CRC-16-CCITT, MSB first, no reflection, no final XOR.
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/cfg_crc16.sv
// rtl/cfg_crc16.sv - bit-serial CRC-16 with restart and enable
module cfg_crc16
    import cfg_loader_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc_next
);

    logic [15:0] crc_q;
    logic [15:0] base;
    logic        fb;

    // Next CRC value; a restart folds the seed in so the first bit is not lost.
    always_comb begin
        base     = init ? CRC_INIT : crc_q;
        fb       = base[15] ^ bit_in;
        crc_next = crc_q;
        if (en) begin
            crc_next = {base[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
    end

    // CRC state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_next;
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - column config-chain loader; frame CRC output enabled by CFG_LOADER_CRC_EN
module cfg_chain_loader
    import cfg_loader_pkg::*;
#(
    parameter int ID_WIDTH   = 3,
    parameter int SHIFT_LEN  = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int GAP_CYCLES = 2
)
(
    input  logic                 clk,
    input  logic                 crst,
    input  logic                 host_valid,
    output logic                 host_ready,
    input  logic [SHIFT_LEN-1:0] host_data,
    output logic                 cfg_in_start,
    output logic                 cfg_bit_in,
    output logic                 cfg_bit_en,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          crc
);

    localparam int CNT_LSB = HDR_ID_LSB + ID_WIDTH;
    localparam int CYC_MAX = (SHIFT_LEN > GAP_CYCLES) ? SHIFT_LEN : GAP_CYCLES;
    localparam int BIT_W   = $clog2(CYC_MAX + 1);

    state_t                state, state_d;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_d;
    logic [CNT_WIDTH-1:0]  rem, rem_d;
    logic [CNT_WIDTH-1:0]  req, req_d;
    logic [SHIFT_LEN-1:0]  shreg, shreg_d;
    logic [SHIFT_LEN-1:0]  pf_data, pf_data_d;
    logic                  pf_full, pf_full_d;
    logic                  accept;
    logic                  ready_d, start_d, bit_d, en_d, busy_d, done_d;

    assign accept = host_valid & host_ready;

    // Next-state, datapath and next-cycle output decode. Outputs are computed
    // from the next state so every port comes straight from a flop.
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        rem_d     = rem;
        req_d     = req;
        shreg_d   = shreg;
        pf_data_d = pf_data;
        pf_full_d = pf_full;
        start_d   = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    // ID is left-aligned so HDR and SHIFT share one MSB-first shifter.
                    shreg_d   = {host_data[HDR_ID_LSB +: ID_WIDTH], {(SHIFT_LEN-ID_WIDTH){1'b0}}};
                    rem_d     = host_data[CNT_LSB +: CNT_WIDTH];
                    req_d     = host_data[CNT_LSB +: CNT_WIDTH];
                    pf_full_d = 1'b0;
                    bit_cnt_d = '0;
                    start_d   = 1'b1;
                    state_d   = HDR;
                end
            end
            HDR: begin
                if (accept) begin
                    pf_data_d = host_data;
                    pf_full_d = 1'b1;
                    req_d     = req - CNT_WIDTH'(1);
                end
                shreg_d = shreg << 1;
                if (bit_cnt == BIT_W'(ID_WIDTH - 1)) begin
                    bit_cnt_d = '0;
                    if (rem == '0) begin
                        state_d = GAP;
                    end else if (pf_full_d) begin
                        shreg_d   = pf_data_d;
                        pf_full_d = 1'b0;
                        state_d   = SHIFT;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    bit_cnt_d = bit_cnt + BIT_W'(1);
                end
            end
            LOAD: begin
                // Buffer is always empty here, so the word goes straight to the shifter.
                if (accept) begin
                    shreg_d   = host_data;
                    req_d     = req - CNT_WIDTH'(1);
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    pf_data_d = host_data;
                    pf_full_d = 1'b1;
                    req_d     = req - CNT_WIDTH'(1);
                end
                shreg_d = shreg << 1;
                if (bit_cnt == BIT_W'(SHIFT_LEN - 1)) begin
                    bit_cnt_d = '0;
                    rem_d     = rem - CNT_WIDTH'(1);
                    if (rem == CNT_WIDTH'(1)) begin
                        state_d = GAP;
                    end else if (pf_full_d) begin
                        shreg_d   = pf_data_d;
                        pf_full_d = 1'b0;
                        state_d   = SHIFT;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    bit_cnt_d = bit_cnt + BIT_W'(1);
                end
            end
            GAP: begin
                if (bit_cnt == BIT_W'(GAP_CYCLES - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt + BIT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The host is only asked for words that still have a slot to land in.
        ready_d = (state_d == IDLE) ||
                  (((state_d == HDR) || (state_d == LOAD) || (state_d == SHIFT)) &&
                   !pf_full_d && (req_d != '0));
        en_d    = (state_d == HDR) || (state_d == SHIFT);
        bit_d   = en_d & shreg_d[SHIFT_LEN-1];
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == GAP) && (bit_cnt_d == BIT_W'(GAP_CYCLES - 1));
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!crst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            rem          <= '0;
            req          <= '0;
            shreg        <= '0;
            pf_data      <= '0;
            pf_full      <= 1'b0;
            host_ready   <= 1'b0;
            cfg_in_start <= 1'b0;
            cfg_bit_in   <= 1'b0;
            cfg_bit_en   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            bit_cnt      <= bit_cnt_d;
            rem          <= rem_d;
            req          <= req_d;
            shreg        <= shreg_d;
            pf_data      <= pf_data_d;
            pf_full      <= pf_full_d;
            host_ready   <= ready_d;
            cfg_in_start <= start_d;
            cfg_bit_in   <= bit_d;
            cfg_bit_en   <= en_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

`ifdef CFG_LOADER_CRC_EN
    logic [15:0] crc_next;

    // The CRC follows exactly what the chain samples, so it is fed from the output flops.
    cfg_crc16 u_crc (
        .clk      (clk),
        .resetn   (crst),
        .init     (cfg_in_start),
        .en       (cfg_bit_en),
        .bit_in   (cfg_bit_in),
        .crc_next (crc_next)
    );

    // Publish the frame CRC together with done and hold it until the next frame ends.
    always_ff @(posedge clk) begin
        if (!crst) begin
            crc <= 16'h0000;
        end else if (done_d) begin
            crc <= crc_next;
        end
    end
`else
    assign crc = 16'h0000;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb/tb_cfg_chain_loader.sv - scoreboard bench for cfg_chain_loader
module tb_cfg_chain_loader;

    localparam int ID_W = 3;
    localparam int SL   = 16;
    localparam int CW   = 8;
    localparam int GAP  = 2;

    typedef struct packed {
        logic start;
        logic b;
    } exp_bit_t;

    logic          clk = 1'b0;
    logic          crst = 1'b0;
    logic          host_valid = 1'b0;
    logic [SL-1:0] host_data = '0;
    logic          host_ready;
    logic          cfg_in_start;
    logic          cfg_bit_in;
    logic          cfg_bit_en;
    logic          busy;
    logic          done;
    logic [15:0]   crc;

    exp_bit_t      exp_bits[$];
    logic [15:0]   exp_crc[$];
    logic [15:0]   crc_m;
    logic [SL-1:0] chunk_mem[256];

    int n_total = 0;
    int n_pass  = 0;
    int cyc = 0, acc_total = 0, f_hdr = 0, f_first = 0, f_last = 0, f_en = 0;
    int f_done = 0, f_dones = 0, f_rdy_busy = 0, rdy_gap_total = 0;

    always #5 clk = ~clk;

    cfg_chain_loader #(
        .ID_WIDTH   (ID_W),
        .SHIFT_LEN  (SL),
        .CNT_WIDTH  (CW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk          (clk),
        .crst         (crst),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_data    (host_data),
        .cfg_in_start (cfg_in_start),
        .cfg_bit_in   (cfg_bit_in),
        .cfg_bit_en   (cfg_bit_en),
        .busy         (busy),
        .done         (done),
        .crc          (crc)
    );

    task automatic check(input string name, input longint got, input longint want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Monitor: pops the scoreboard on every sampled bit and every done.
    always @(negedge clk) begin
        exp_bit_t e;
        logic [15:0] ec;
        cyc++;
        if (host_valid && host_ready) begin
            acc_total++;
            if (!busy) begin
                f_hdr      = cyc;
                f_rdy_busy = 0;
            end
        end
        if (busy && host_ready) f_rdy_busy++;
        if (busy && host_ready && exp_bits.size() == 0) rdy_gap_total++;
        if (cfg_bit_en) begin
            if (cfg_in_start) begin
                f_en    = 0;
                f_first = cyc;
                f_dones = 0;
                check("start_latency", cyc, f_hdr + 1);
            end
            f_en++;
            f_last = cyc;
            check("bit_expected", exp_bits.size() > 0, 1);
            if (exp_bits.size() > 0) begin
                e = exp_bits.pop_front();
                check("bit_start", {cfg_in_start, cfg_bit_in}, {e.start, e.b});
            end
        end
        if (done) begin
            f_done = cyc;
            f_dones++;
            check("crc_expected", exp_crc.size() > 0, 1);
            if (exp_crc.size() > 0) begin
                ec = exp_crc.pop_front();
                check("crc_at_done", crc, ec);
            end
        end
    end

    task automatic push_word(input logic [SL-1:0] d, input int pre, output bit ok);
        int t;
        repeat (pre) @(posedge clk);
        if (pre > 0) #1;
        host_valid = 1'b1;
        host_data  = d;
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 300) begin
            @(negedge clk);
            if (host_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
            t++;
        end
        host_valid = 1'b0;
    endtask

    task automatic build_frame(input logic [ID_W-1:0] id, input int n);
        crc_m = 16'hFFFF;
        for (int i = ID_W - 1; i >= 0; i--) begin
            exp_bits.push_back('{start: (i == ID_W - 1), b: id[i]});
            crc_m = crc_step(crc_m, id[i]);
        end
        for (int c = 0; c < n; c++) begin
            for (int i = SL - 1; i >= 0; i--) begin
                exp_bits.push_back('{start: 1'b0, b: chunk_mem[c][i]});
                crc_m = crc_step(crc_m, chunk_mem[c][i]);
            end
        end
    endtask

    function automatic logic [SL-1:0] header(input logic [ID_W-1:0] id, input int n);
        logic [SL-1:0] h;
        h = '0;
        h[ID_W-1:0]   = id;
        h[ID_W +: CW] = n[CW-1:0];
        return h;
    endfunction

    task automatic run_frame(input logic [ID_W-1:0] id, input int n, input int stall_at,
                             input int stall_dly, input int exp_gaps);
        bit ok;
        bit all_ok;
        int acc0;
        int t;
        build_frame(id, n);
`ifdef CFG_LOADER_CRC_EN
        exp_crc.push_back(crc_m);
`else
        exp_crc.push_back(16'h0000);
`endif
        acc0 = acc_total;
        push_word(header(id, n), 0, ok);
        all_ok = ok;
        for (int c = 0; c < n; c++) begin
            push_word(chunk_mem[c], (c == stall_at) ? stall_dly : 0, ok);
            all_ok = all_ok & ok;
        end
        check("words_taken", all_ok, 1);
        // Keep offering a word so any acceptance beyond N would be counted.
        host_valid = 1'b1;
        host_data  = 16'hDEAD;
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 6000) begin
            @(negedge clk);
            if (done) ok = 1'b1;
            t++;
        end
        @(posedge clk);
        #1;
        host_valid = 1'b0;
        @(posedge clk);
        #1;
        check("done_seen", ok, 1);
        check("en_count", f_en, ID_W + SL * n);
        check("en_bubbles", f_last - f_first + 1 - f_en, exp_gaps);
        check("done_after_last_bit", f_done - f_last, GAP);
        if (stall_at < 0) check("frame_length", f_done - f_hdr, ID_W + SL * n + GAP);
        check("words_accepted", acc_total - acc0, n + 1);
        check("done_pulses", f_dones, 1);
        if (n == 0) check("ready_while_busy", f_rdy_busy, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {host_ready, cfg_in_start, cfg_bit_in, cfg_bit_en, busy, done, crc}, 0);
    endtask

    initial begin
        bit ok;
        bit reached;
        int t;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_outputs");
        @(posedge clk);
        #1;
        crst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_release", {host_ready, busy}, 2'b10);
        @(posedge clk);
        #1;

        chunk_mem[0] = 16'hA5C3;
        run_frame(3'd5, 1, -1, 0, 0);

        chunk_mem[0] = 16'h8001;
        chunk_mem[1] = 16'h7E5A;
        chunk_mem[2] = 16'hF00F;
        run_frame(3'd3, 3, -1, 0, 0);

        chunk_mem[0] = 16'h1357;
        chunk_mem[1] = 16'h2468;
        run_frame(3'd6, 2, 1, ID_W + SL + 7 - 2, 7);

        run_frame(3'd2, 0, -1, 0, 0);

        // Abandon a frame at bit 8 of its chunk.
        chunk_mem[0] = 16'h3C96;
        build_frame(3'd3, 1);
        push_word(header(3'd3, 1), 0, ok);
        push_word(chunk_mem[0], 0, ok);
        reached = 1'b0;
        t = 0;
        while (!reached && t < 100) begin
            @(posedge clk);
            #1;
            if (f_en == ID_W + 8) reached = 1'b1;
            t++;
        end
        check("reached_bit8", reached, 1);
        crst = 1'b0;
        @(posedge clk);
        #1;
        exp_bits.delete();
        @(negedge clk);
        check_reset_outputs("midframe_reset_outputs");
        @(posedge clk);
        #1;
        crst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_midframe_release", {host_ready, busy}, 2'b10);
        @(posedge clk);
        #1;

        chunk_mem[0] = 16'hCAFE;
        chunk_mem[1] = 16'h0F1E;
        run_frame(3'd7, 2, -1, 0, 0);

        chunk_mem[0] = 16'h0000;
        run_frame(3'd0, 1, -1, 0, 0);

        for (int i = 0; i < 255; i++) chunk_mem[i] = 16'(i * 16'h0101) ^ 16'h5A3C;
        run_frame(3'd4, 255, -1, 0, 0);

        check("bits_left_over", exp_bits.size(), 0);
        check("crcs_left_over", exp_crc.size(), 0);
        check("ready_in_gap", rdy_gap_total, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
